priority_encoder: RTL and testbench
===================================

// Module: priority_encoder
// PURPOSE
//   Registered 8-to-3 priority encoder. Converts an 8-bit request vector into
//   the 3-bit index of its highest set bit, plus a valid flag.
//   Used wherever a one-hot or multi-hot request word must become a binary
//   index, e.g. arbitration or interrupt-source identification.
//   One clock; output registered with 1-cycle latency.
// PARAMETERS
//   IN_W   8               request vector width; must be a power of 2, >= 2
//   OUT_W  $clog2(IN_W)    index width; 3 at default; derived, do not override
// PORTS
//   clk    in   1      clock; all state updates on rising edge
//   rst    in   1      reset; synchronous, active-high
//   en     in   1      capture enable; 1 = register new encode result
//   in     in   IN_W   request vector; bit i set = request from source i
//   out    out  OUT_W  index of highest set bit of in, registered
//   valid  out  1      1 = at least one bit of in was set at capture
// BEHAVIOUR
//   - Reset (rst=1 at a rising edge): out=0, valid=0 (and multi=0 if present).
//     rst has priority over en.
//   - Priority: the highest-numbered set bit wins.
//     Example: in=8'b0100_0100 -> out=6.
//   - Capture edge (en=1, rst=0):
//     - out <= index of MSB set in in;
//     - valid <= |in.
//   - Latency: the result appears on out/valid one clock after in is sampled.
//   - in=0 with en=1: out <= 0, valid <= 0.
//     Consumers must qualify out with valid, because in=8'h01 also gives out=0.
//   - en=0: out and valid hold their previous values.
//   - in is sampled only at the clock edge; changes between edges have no
//     effect, and there are no glitches on the outputs.
//   - Mid-operation reset: the next edge with rst=1 clears the outputs,
//     regardless of in and en.
//   - Width rule: out is zero-extended index arithmetic only. No X may
//     propagate for any fully-known input value.
// CONFIGURATION
//   Macro PRIORITY_ENCODER_MULTI_EN:
//   - Defined: adds output port multi (1 bit, registered). On a capture edge,
//     multi <= 1 when more than one bit of in is set, else 0. multi resets to
//     0 and holds when en=0. Encoding of out is unchanged.
//   - Undefined: no multi port and no population-count logic. All other
//     behaviour is identical.
// STRUCTURE
//   - Shared package prio_enc_pkg holds:
//     - localparam IN_W_DEFAULT = 8;
//     - a function clog2 for OUT_W derivation;
//     - the reset value constant IDX_RST = 0.
//   - Sub-module prio_enc_comb: purely combinational and parameterised by IN_W.
//     - Built as a log2-depth tree of 2-input priority cells: the upper half
//       wins when its valid is set.
//     - Outputs idx and any.
//   - Top level: prio_enc_comb, the output register stage with en/rst, and
//     the optional multi-detect logic.
// TESTING
//   1. Reset:
//      - rst=1 for 2 cycles with in=8'hFF, en=1 -> out=0, valid=0.
//      - Release rst -> one cycle later out=7, valid=1.
//   2. One-hot sweep, en=1:
//      - in=8'h04 -> 2; 8'h20 -> 5; 8'h08 -> 3; 8'h10 -> 4; 8'h01 -> 0;
//        8'h80 -> 7.
//      - valid=1 for each; each result appears one cycle after its input.
//   3. Multi-hot priority:
//      - in=8'h44 -> out=6; in=8'h0F -> out=3.
//      - With PRIORITY_ENCODER_MULTI_EN defined, multi=1 for both cases and
//        multi=0 for 8'h10.
//   4. Zero input: in=8'h00, en=1 -> out=0, valid=0.
//      Compare with in=8'h01 -> out=0, valid=1.
//   5. Enable hold:
//      - Capture 8'h20 (out=5), then set en=0 and drive 8'h02 for 3 cycles
//        -> out stays 5, valid=1.
//      - Set en=1 -> out=1.
//   6. Mid-run reset: while en=1 and in=8'h40, pulse rst for 1 cycle
//      -> out=0, valid=0 that cycle, then out=6 on the next edge.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the registered priority encoder.
package prio_enc_pkg;

  localparam int unsigned IN_W_DEFAULT = 8;
  localparam int unsigned IDX_RST      = 0;

  // Ceiling log2, used to derive the index width from the request width.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// Combinational priority encoder built as a recursive tree of 2-input cells;
// the upper half wins whenever it holds any set bit.
module prio_enc_comb
  import prio_enc_pkg::*;
#(
  parameter int unsigned IN_W = IN_W_DEFAULT,
  localparam int unsigned OUT_W = clog2(IN_W)
) (
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] idx,
  output logic             any
);

  if (IN_W == 2) begin : g_leaf
    assign any = in[1] | in[0];
    assign idx = in[1];
  end else begin : g_node
    localparam int unsigned HALF = IN_W / 2;

    logic [OUT_W-2:0] lo_idx;
    logic [OUT_W-2:0] hi_idx;
    logic             lo_any;
    logic             hi_any;

    prio_enc_comb #(.IN_W(HALF)) u_lo (
      .in  (in[HALF-1:0]),
      .idx (lo_idx),
      .any (lo_any)
    );

    prio_enc_comb #(.IN_W(HALF)) u_hi (
      .in  (in[IN_W-1:HALF]),
      .idx (hi_idx),
      .any (hi_any)
    );

    // The half-select bit becomes the MSB of the merged index.
    assign any = hi_any | lo_any;
    assign idx = hi_any ? {1'b1, hi_idx} : {1'b0, lo_idx};
  end

endmodule

// File: rtl/priority_encoder.sv
// Registered priority encoder: index of the highest set request bit plus valid.
// Define PRIORITY_ENCODER_MULTI_EN to add the registered multi-hit flag "multi".
module priority_encoder
  import prio_enc_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEFAULT,
  parameter int unsigned OUT_W = clog2(IN_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out,
  output logic             valid
`ifdef PRIORITY_ENCODER_MULTI_EN
  ,
  output logic             multi
`endif
);

  logic [OUT_W-1:0] idx_c;
  logic             any_c;

  prio_enc_comb #(.IN_W(IN_W)) u_comb (
    .in  (in),
    .idx (idx_c),
    .any (any_c)
  );

  // Reset dominates enable; with en low the previous result is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      out   <= OUT_W'(IDX_RST);
      valid <= 1'b0;
    end else if (en) begin
      out   <= idx_c;
      valid <= any_c;
    end
  end

`ifdef PRIORITY_ENCODER_MULTI_EN
  logic multi_c;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_c = |(in & (in - IN_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      multi <= 1'b0;
    end else if (en) begin
      multi <= multi_c;
    end
  end
`else
  // Single-hit build: no multi-hit detection.
`endif

endmodule

// File: tb/tb_priority_encoder.sv
// Directed, table-driven bench for priority_encoder (default 8-bit build,
// with the multi flag checked when PRIORITY_ENCODER_MULTI_EN is defined).
module tb_priority_encoder;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] data;
    logic [2:0] exp_out;
    logic       exp_valid;
    logic       exp_multi;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] in;
  logic [2:0] out;
  logic       valid;
`ifdef PRIORITY_ENCODER_MULTI_EN
  logic       multi;
`endif

  int total;
  int bad;

  priority_encoder dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .in    (in),
    .out   (out),
    .valid (valid)
`ifdef PRIORITY_ENCODER_MULTI_EN
    ,
    .multi (multi)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    en    = 1'b0;
    in    = 8'h00;

    // rst, en, in, out, valid, multi (expected after the edge)
    vecs.push_back('{1'b1, 1'b1, 8'hFF, 3'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 8'hFF, 3'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'hFF, 3'd7, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 8'h04, 3'd2, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h20, 3'd5, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h08, 3'd3, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h10, 3'd4, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h80, 3'd7, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h44, 3'd6, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 8'h0F, 3'd3, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 8'h10, 3'd4, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h20, 3'd5, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h02, 3'd5, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h02, 3'd5, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h02, 3'd5, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h02, 3'd1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h40, 3'd6, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 8'h40, 3'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h40, 3'd6, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'h40, 3'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h03, 3'd1, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 3'd1, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 8'hC0, 3'd7, 1'b1, 1'b1});

    #2;
    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      en  = vecs[i].en;
      in  = vecs[i].data;
      step();
      check($sformatf("row%0d out", i), int'(out), int'(vecs[i].exp_out));
      check($sformatf("row%0d valid", i), int'(valid), int'(vecs[i].exp_valid));
`ifdef PRIORITY_ENCODER_MULTI_EN
      check($sformatf("row%0d multi", i), int'(multi), int'(vecs[i].exp_multi));
`endif
    end

    // Latency: a new input must not show before the next edge.
    rst = 1'b0;
    en  = 1'b1;
    in  = 8'h08;
    #3;
    check("latency pre-edge out", int'(out), 7);
    step();
    check("latency post-edge out", int'(out), 3);

    // Input wiggles between edges have no effect; only the edge value counts.
    in = 8'h80;
    #3;
    in = 8'h02;
    #2;
    check("between-edge out", int'(out), 3);
    step();
    check("edge sample out", int'(out), 1);
    check("edge sample valid", int'(valid), 1);

    // Zero input after a valid capture clears valid and index.
    in = 8'h00;
    step();
    check("zero out", int'(out), 0);
    check("zero valid", int'(valid), 0);
`ifdef PRIORITY_ENCODER_MULTI_EN
    check("zero multi", int'(multi), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
